matmul_ctrl: RTL and testbench

Sequencer for the 8-bit matrix-multiply datapath. Accepts a byte stream holding matrices A and B into the input memory, then walks every output element through clear / operand load / multiply-accumulate / write-back. Finally streams the 18-bit results out of the output memory as three bytes each under a valid/ready handshake. Sits directly upstream of the datapath and drives all of its control inputs; `in_data` connects straight to the datapath `data_in`, and `out_valid` qualifies the datapath `Dataout`.

---
 rtl/matmul_pkg.sv | 76 +++++++
 rtl/matmul_ctrl_if.sv | 24 ++
 rtl/matmul_idx_cnt.sv | 49 ++++
 rtl/matmul_ctrl.sv | 171 +++++++++++++++++
 tb/tb_matmul_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/matmul_pkg.sv
// matmul_pkg: shared state encoding, widths and part codes for the
// matmul sequencer (matmul_ctrl, matmul_idx_cnt, matmul_ctrl_if).
package matmul_pkg;

   localparam int N_DEF  = 4;
   localparam int ADDR_W = 5;
   localparam int BYTE_W = 8;
   localparam int RES_W  = 18;
   localparam int IDX_W  = 3;

   localparam logic [1:0] PART_LO  = 2'b00;
   localparam logic [1:0] PART_MID = 2'b01;
   localparam logic [1:0] PART_HI  = 2'b10;

   typedef enum logic [3:0] {
      S_IDLE,
      S_LOAD,
      S_CLR,
      S_RD_A,
      S_RD_B,
      S_LD_B,
      S_ACC,
      S_WR,
      S_OUT_RD,
      S_OUT_BYTE,
      S_DONE
   } state_t;

   typedef struct packed {
      logic in_ready;
      logic out_valid;
      logic busy;
      logic done;
      logic memin_read;
      logic memout_read;
      logic memout_write;
      logic reswrite;
      logic awrite;
      logic bwrite;
      logic clear_res;
   } ctl_t;

   // Moore strobe pattern for each state.
   function automatic ctl_t ctl_of(state_t s);
      ctl_t c;
      c = '0;
      c.busy = (s != S_IDLE);
      case (s)
         S_LOAD:     c.in_ready = 1'b1;
         S_CLR:      c.clear_res = 1'b1;
         S_RD_A:     c.memin_read = 1'b1;
         S_RD_B: begin
            c.memin_read = 1'b1;
            c.awrite     = 1'b1;
         end
         S_LD_B:     c.bwrite = 1'b1;
         S_ACC:      c.reswrite = 1'b1;
         S_WR:       c.memout_write = 1'b1;
         S_OUT_RD:   c.memout_read = 1'b1;
         S_OUT_BYTE: c.out_valid = 1'b1;
         S_DONE:     c.done = 1'b1;
         default:    ;
      endcase
      return c;
   endfunction

   // Byte index within a result triple to datapath part code.
   function automatic logic [1:0] part_of(logic [1:0] b);
      logic [1:0] p;
      p = PART_HI;
      if (b == 2'd0) p = PART_LO;
      else if (b == 2'd1) p = PART_MID;
      return p;
   endfunction

endpackage

// File: rtl/matmul_ctrl_if.sv
// matmul_ctrl_if: load-stream and result-stream valid/ready handshakes.
// master = environment side, slave = matmul_ctrl side.
interface matmul_ctrl_if;

   logic in_valid;
   logic in_ready;
   logic out_valid;
   logic out_ready;

   modport master (
      output in_valid,
      output out_ready,
      input  in_ready,
      input  out_valid
   );

   modport slave (
      input  in_valid,
      input  out_ready,
      output in_ready,
      output out_valid
   );

endinterface

// File: rtl/matmul_idx_cnt.sv
// matmul_idx_cnt: nested i/j/k element counters for the compute walk.
// k steps per MAC, j then i step per written element; both wrap.
module matmul_idx_cnt
   import matmul_pkg::*;
#(
   parameter int N = N_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             step_k,
   input  logic             step_ij,
   output logic [IDX_W-1:0] i,
   output logic [IDX_W-1:0] j,
   output logic [IDX_W-1:0] k,
   output logic             last_k,
   output logic             last_ij
);

   localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

   assign last_k  = (k == LAST);
   assign last_ij = (i == LAST) && (j == LAST);

   // Advance k on MAC, j/i on write-back; wrap to zero after the last.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         i <= '0;
         j <= '0;
         k <= '0;
      end else if (clr) begin
         i <= '0;
         j <= '0;
         k <= '0;
      end else begin
         if (step_k)
            k <= last_k ? '0 : k + IDX_W'(1);
         if (step_ij) begin
            if (j == LAST) begin
               j <= '0;
               i <= (i == LAST) ? '0 : i + IDX_W'(1);
            end else begin
               j <= j + IDX_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/matmul_ctrl.sv
// matmul_ctrl: load / compute / stream-out sequencer for the 8-bit
// matmul datapath. Optional MATMUL_CTRL_CYCLE_CNT_EN adds cycle_cnt.
module matmul_ctrl
   import matmul_pkg::*;
#(
   parameter int N = N_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   matmul_ctrl_if.slave      hs,
   output logic              busy,
   output logic              done,
   output logic              memin_read,
   output logic              memin_write,
   output logic              memout_read,
   output logic              memout_write,
   output logic              Reswrite,
   output logic              Awrite,
   output logic              Bwrite,
   output logic              clearRes,
   output logic [ADDR_W-1:0] addr,
   output logic [ADDR_W-1:0] memout_addr,
   output logic [1:0]        part
`ifdef MATMUL_CTRL_CYCLE_CNT_EN
   ,
   output logic [15:0]       cycle_cnt
`endif
);

   localparam logic [ADDR_W-1:0] LD_LAST = ADDR_W'(2 * N * N - 1);
   localparam logic [ADDR_W-1:0] E_LAST  = ADDR_W'(N * N - 1);
   localparam logic [ADDR_W-1:0] B_BASE  = ADDR_W'(N * N);
   localparam logic [ADDR_W-1:0] NA      = ADDR_W'(N);

   state_t            state;
   state_t            state_d;
   ctl_t              ctl;
   logic [ADDR_W-1:0] ld_cnt;
   logic [ADDR_W-1:0] e_cnt;
   logic [1:0]        b_idx;
   logic [IDX_W-1:0]  i;
   logic [IDX_W-1:0]  j;
   logic [IDX_W-1:0]  k;
   logic              last_k;
   logic              last_ij;
   logic              take_start;
   logic              take_byte;
   logic              take_out;
   logic              last_byte;

   assign take_start = (state == S_IDLE) && start;
   assign take_byte  = (state == S_LOAD) && hs.in_valid;
   assign take_out   = (state == S_OUT_BYTE) && hs.out_ready;
   assign last_byte  = take_out && (b_idx == 2'd2);

   matmul_idx_cnt #(.N(N)) u_idx (
      .clk     (clk),
      .rst     (rst),
      .clr     (take_start),
      .step_k  (state == S_ACC),
      .step_ij (state == S_WR),
      .i       (i),
      .j       (j),
      .k       (k),
      .last_k  (last_k),
      .last_ij (last_ij)
   );

   // Next-state selection.
   always_comb begin
      state_d = state;
      unique case (state)
         S_IDLE:     if (start) state_d = S_LOAD;
         S_LOAD:     if (take_byte && ld_cnt == LD_LAST)
                        state_d = S_CLR;
         S_CLR:      state_d = S_RD_A;
         S_RD_A:     state_d = S_RD_B;
         S_RD_B:     state_d = S_LD_B;
         S_LD_B:     state_d = S_ACC;
         S_ACC:      state_d = last_k ? S_WR : S_RD_A;
         S_WR:       state_d = last_ij ? S_OUT_RD : S_CLR;
         S_OUT_RD:   state_d = S_OUT_BYTE;
         S_OUT_BYTE: if (last_byte)
                        state_d = (e_cnt == E_LAST) ? S_DONE : S_OUT_RD;
         S_DONE:     state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   // State, registered strobes and phase counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= S_IDLE;
         ctl    <= '0;
         ld_cnt <= '0;
         e_cnt  <= '0;
         b_idx  <= '0;
      end else begin
         state <= state_d;
         ctl   <= ctl_of(state_d);
         if (take_start)
            ld_cnt <= '0;
         else if (take_byte)
            ld_cnt <= ld_cnt + ADDR_W'(1);
         if (take_start)
            e_cnt <= '0;
         else if (last_byte && e_cnt != E_LAST)
            e_cnt <= e_cnt + ADDR_W'(1);
         if (state == S_OUT_RD)
            b_idx <= '0;
         else if (take_out)
            b_idx <= (b_idx == 2'd2) ? 2'd0 : b_idx + 2'd1;
      end
   end

   assign busy         = ctl.busy;
   assign done         = ctl.done;
   assign hs.in_ready  = ctl.in_ready;
   assign hs.out_valid = ctl.out_valid;
   assign memin_read   = ctl.memin_read;
   assign memout_read  = ctl.memout_read;
   assign memout_write = ctl.memout_write;
   assign Reswrite     = ctl.reswrite;
   assign Awrite       = ctl.awrite;
   assign Bwrite       = ctl.bwrite;
   assign clearRes     = ctl.clear_res;
   assign memin_write  = take_byte;

   // Input-memory address: load slot, A(i,k) or B(k,j).
   always_comb begin
      addr = '0;
      case (state)
         S_LOAD: addr = ld_cnt;
         S_RD_A: addr = ADDR_W'(i) * NA + ADDR_W'(k);
         S_RD_B: addr = B_BASE + ADDR_W'(k) * NA + ADDR_W'(j);
         default: addr = '0;
      endcase
   end

   // Output-memory address: C(i,j) on write, element index on read-out.
   always_comb begin
      memout_addr = '0;
      case (state)
         S_WR:       memout_addr = ADDR_W'(i) * NA + ADDR_W'(j);
         S_OUT_RD:   memout_addr = e_cnt;
         S_OUT_BYTE: memout_addr = e_cnt;
         default:    memout_addr = '0;
      endcase
   end

   assign part = (state == S_OUT_BYTE) ? part_of(b_idx) : PART_LO;

`ifdef MATMUL_CTRL_CYCLE_CNT_EN
   logic in_compute;

   assign in_compute = state inside {S_CLR, S_RD_A, S_RD_B,
                                     S_LD_B, S_ACC, S_WR};

   // Saturating count of compute-phase cycles for the current job.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cycle_cnt <= '0;
      else if (take_start)
         cycle_cnt <= '0;
      else if (in_compute && cycle_cnt != 16'hFFFF)
         cycle_cnt <= cycle_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_matmul_ctrl.sv
// tb_matmul_ctrl: drives matmul_ctrl with a behavioural datapath and
// checks streamed result bytes against a reference matrix product.
`timescale 1ns/1ps
module tb_matmul_ctrl;
   import matmul_pkg::*;

   localparam int N = 4;

   typedef struct {
      int         pat;
      bit         thr;
      bit         bp;
      bit         glitch;
      logic [17:0] c0;
      logic [17:0] cl;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0;
   logic [7:0] in_data = '0;
   logic busy, done, memin_read, memin_write, memout_read, memout_write;
   logic Reswrite, Awrite, Bwrite, clearRes;
   logic [4:0] addr, memout_addr;
   logic [1:0] part;
`ifdef MATMUL_CTRL_CYCLE_CNT_EN
   logic [15:0] cycle_cnt;
`endif

   always #5 clk = ~clk;

   matmul_ctrl_if hs ();

   matmul_ctrl #(.N(N)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .hs           (hs),
      .busy         (busy),
      .done         (done),
      .memin_read   (memin_read),
      .memin_write  (memin_write),
      .memout_read  (memout_read),
      .memout_write (memout_write),
      .Reswrite     (Reswrite),
      .Awrite       (Awrite),
      .Bwrite       (Bwrite),
      .clearRes     (clearRes),
      .addr         (addr),
      .memout_addr  (memout_addr),
      .part         (part)
`ifdef MATMUL_CTRL_CYCLE_CNT_EN
      ,
      .cycle_cnt    (cycle_cnt)
`endif
   );

   // Behavioural datapath with registered memory reads.
   logic [7:0]       memin [32];
   logic [RES_W-1:0] memout [32];
   logic [7:0]       min_q, a_r, b_r, dout;
   logic [RES_W-1:0] res, mout_q;

   always @(posedge clk) begin
      if (memin_write) memin[addr] <= in_data;
      if (memin_read) min_q <= memin[addr];
      if (Awrite) a_r <= min_q;
      if (Bwrite) b_r <= min_q;
      if (clearRes) res <= '0;
      else if (Reswrite) res <= res + RES_W'(a_r) * RES_W'(b_r);
      if (memout_write) memout[memout_addr] <= res;
      if (memout_read) mout_q <= memout[memout_addr];
   end

   always_comb begin
      dout = '0;
      case (part)
         2'b00:   dout = mout_q[7:0];
         2'b01:   dout = mout_q[15:8];
         default: dout = {6'b0, mout_q[17:16]};
      endcase
   end

   int n_cmp = 0;
   int n_err = 0;
   int ma [N][N];
   int mb [N][N];
   logic [BYTE_W-1:0] exp_q [$];
   logic [23:0] got_c [N*N];
   int wr_cnt, comp_cyc, out_cyc, oc;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] outs();
      return {8'b0, busy, done, hs.in_ready, hs.out_valid,
              memin_read, memin_write, memout_read, memout_write,
              Reswrite, Awrite, Bwrite, clearRes,
              addr, memout_addr, part};
   endfunction

   function automatic logic [7:0] byte_of(int idx);
      if (idx < N * N) return 8'(ma[idx / N][idx % N]);
      return 8'(mb[(idx - N * N) / N][(idx - N * N) % N]);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: load writes, phase cycle counts, result scoreboard.
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (memin_write) begin
            chk("wr_addr", 32'(addr), wr_cnt);
            wr_cnt++;
         end
         if (clearRes | memin_read | Bwrite | Reswrite | memout_write)
            comp_cyc++;
         if (memout_read | hs.out_valid)
            out_cyc++;
         if (hs.out_valid && hs.out_ready) begin
            if (exp_q.size() == 0) begin
               chk("sb_empty", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("data", 32'(dout), 32'(e));
            end
            chk("part", 32'(part), oc % 3);
            chk("oaddr", 32'(memout_addr), oc / 3);
            if (oc < 3 * N * N)
               got_c[oc / 3][(oc % 3) * 8 +: 8] = dout;
            oc++;
         end
      end
   end

   task automatic build(input int pat);
      int s;
      logic [17:0] c;
      for (int r = 0; r < N; r++)
         for (int q = 0; q < N; q++)
            case (pat)
               0: begin
                  ma[r][q] = (r == q) ? 1 : 0;
                  mb[r][q] = r * N + q + 1;
               end
               1: begin
                  ma[r][q] = 255;
                  mb[r][q] = 255;
               end
               default: begin
                  ma[r][q] = 1;
                  mb[r][q] = q + 1;
               end
            endcase
      for (int r = 0; r < N; r++)
         for (int q = 0; q < N; q++) begin
            s = 0;
            for (int x = 0; x < N; x++) s += ma[r][x] * mb[x][q];
            c = 18'(s);
            exp_q.push_back(c[7:0]);
            exp_q.push_back(c[15:8]);
            exp_q.push_back({6'b0, c[17:16]});
         end
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("load_entry", 32'(hs.in_ready), 32'd1);
   endtask

   task automatic do_load(input bit thr);
      int  idx = 0;
      int  guard = 0;
      bit  tog = 1'b0;
      bit  acc;
      while (idx < 2 * N * N && guard < 500) begin
         tog = ~tog;
         hs.in_valid = !(thr && !tog);
         in_data = byte_of(idx);
         acc = hs.in_valid && hs.in_ready;
         tick();
         if (acc) idx++;
         guard++;
      end
      hs.in_valid = 1'b0;
      chk("load_bytes", idx, 2 * N * N);
   endtask

   task automatic wait_done(input bit bp, input bit glitch);
      int   cyc = 0;
      int   stall = 0;
      bit   seen = 1'b0;
      bit   held;
      logic [4:0] haddr = '0;
      hs.out_ready = 1'b1;
      while (!seen && cyc < 3000) begin
         start = glitch && (cyc == 50);
         held = !hs.out_ready;
         if (held) begin
            chk("bp_valid", 32'(hs.out_valid), 32'd1);
            chk("bp_part", 32'(part), 32'(PART_MID));
            chk("bp_addr", 32'(memout_addr), 32'(haddr));
         end
         if (bp && stall < 5 && hs.out_valid && part == PART_MID) begin
            hs.out_ready = 1'b0;
            haddr = memout_addr;
            stall++;
         end else begin
            hs.out_ready = 1'b1;
         end
         if (done) begin
            seen = 1'b1;
            chk("done_busy", 32'(busy), 32'd1);
`ifdef MATMUL_CTRL_CYCLE_CNT_EN
            chk("cycle_cnt", 32'(cycle_cnt), 32'd288);
`endif
         end
         tick();
         cyc++;
      end
      start = 1'b0;
      hs.out_ready = 1'b1;
      chk("done_seen", 32'(seen), 32'd1);
      chk("done_pulse", 32'(done), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
`ifdef MATMUL_CTRL_CYCLE_CNT_EN
      chk("cycle_hold", 32'(cycle_cnt), 32'd288);
`endif
   endtask

   task automatic run_job(input vec_t v);
      wr_cnt = 0;
      comp_cyc = 0;
      out_cyc = 0;
      oc = 0;
      for (int q = 0; q < N * N; q++) got_c[q] = '0;
      build(v.pat);
      do_start();
      do_load(v.thr);
      wait_done(v.bp, v.glitch);
      chk("c_first", 32'(got_c[0][17:0]), 32'(v.c0));
      chk("c_last", 32'(got_c[N*N-1][17:0]), 32'(v.cl));
      chk("wr_cnt", wr_cnt, 2 * N * N);
      chk("out_bytes", oc, 3 * N * N);
      chk("sb_left", exp_q.size(), 0);
      chk("comp_cyc", comp_cyc, 288);
      if (!v.bp) chk("out_cyc", out_cyc, 64);
   endtask

   initial begin
      vec_t tbl [4];
      tbl[0] = '{pat: 0, thr: 0, bp: 0, glitch: 0, c0: 18'd1, cl: 18'd16};
      tbl[1] = '{pat: 1, thr: 0, bp: 0, glitch: 0,
                 c0: 18'h3F804, cl: 18'h3F804};
      tbl[2] = '{pat: 0, thr: 1, bp: 0, glitch: 1, c0: 18'd1, cl: 18'd16};
      tbl[3] = '{pat: 2, thr: 0, bp: 1, glitch: 0, c0: 18'd4, cl: 18'd16};

      hs.in_valid = 1'b0;
      hs.out_ready = 1'b1;
      rst = 1'b0;
      #12;
      chk("rst_init_outs", outs(), 32'd0);
`ifdef MATMUL_CTRL_CYCLE_CNT_EN
      chk("rst_init_cnt", 32'(cycle_cnt), 32'd0);
`endif
      tick();
      rst = 1'b1;
      tick();
      tick();
      chk("idle_after_rst", 32'(busy), 32'd0);

      for (int t = 0; t < 4; t++) run_job(tbl[t]);

      // Abort a job with reset while accumulating.
      wr_cnt = 0;
      build(0);
      do_start();
      do_load(1'b0);
      for (int g = 0; g < 100 && !Reswrite; g++) tick();
      chk("acc_reached", 32'(Reswrite), 32'd1);
      rst = 1'b0;
      #1;
      chk("rst_mid_outs", outs(), 32'd0);
      exp_q.delete();
      tick();
      tick();
      chk("rst_hold_outs", outs(), 32'd0);
      rst = 1'b1;
      tick();
      chk("rst_rel_busy", 32'(busy), 32'd0);
      run_job(tbl[1]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
